// File: rtl/parking_pkg.sv
// Shared definitions for the parking gate front end and the occupancy counter.
// Holds the lane state encoding, admission hours and lot capacities.
package parking_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CHECK  = 3'd1,
        OPEN   = 3'd2,
        REJECT = 3'd3,
        CLOSE  = 3'd4
    } lane_state_e;

    localparam int OPEN_HOUR        = 8;
    localparam int LAST_HOUR        = 23;
    localparam int UNI_CAPACITY     = 64;
    localparam int GENERAL_CAPACITY = 192;
    localparam int TOTAL_CAPACITY   = UNI_CAPACITY + GENERAL_CAPACITY;

    function automatic logic hour_open(input logic [4:0] hour);
        return (hour >= 5'(OPEN_HOUR)) && (hour <= 5'(LAST_HOUR));
    endfunction

endpackage

// File: rtl/parking_gate_controller_if.sv
// Car event stream between the gate front end (master) and the occupancy counter (slave).
// Events are single-cycle pulses; the is_uni_* qualifier is stable before and during each pulse.
interface parking_gate_controller_if;

    logic car_entered;
    logic is_uni_car_entered;
    logic car_exited;
    logic is_uni_car_exited;
    logic uni_is_vacated_space;
    logic is_vacated_space;

    modport master (
        output car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
        input  uni_is_vacated_space, is_vacated_space
    );

    modport slave (
        input  car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
        output uni_is_vacated_space, is_vacated_space
    );

endinterface

// File: rtl/parking_lane_fsm.sv
// One gate lane: sensor synchronizers and debouncers, the barrier state machine,
// the open-timeout / close-gap timer and the badge qualifier latch.
module parking_lane_fsm
    import parking_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 16,
    parameter int TIMEOUT_CYC  = 1000,
    parameter int GAP_CYC      = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        loop_i,
    input  logic        pass_i,
    input  logic        badge_i,
    input  logic        grant_i,
    input  logic        busy_i,
    output logic        arm_o,
    output logic        event_o,
    output logic        qual_o,
    output lane_state_e state_o
);

    localparam int DW = $clog2(DEBOUNCE_CYC + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    // Channel 0 is the presence loop, channel 1 the pass sensor.
    logic [1:0]          sync1_q, sync2_q, deb_q, deb_d;
    logic [1:0][DW-1:0]  cnt_q, cnt_d;
    lane_state_e         state_q, state_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic                qual_q, qual_d;
    logic                armed_q, armed_d;
    logic                pass_rise;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            cnt_q   <= '0;
            state_q <= IDLE;
            timer_q <= '0;
            qual_q  <= 1'b0;
            armed_q <= 1'b1;
        end else begin
            sync1_q <= {pass_i, loop_i};
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            timer_q <= timer_d;
            qual_q  <= qual_d;
            armed_q <= armed_d;
        end
    end

    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == DW'(DEBOUNCE_CYC - 1)) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // The FSM reacts to the debounced level on the same edge it is accepted.
    assign pass_rise = deb_d[1] & ~deb_q[1];

    always_comb begin
        state_d = state_q;
        timer_d = timer_q + 1'b1;
        qual_d  = qual_q;
        armed_d = armed_q;
        event_o = 1'b0;
        // A held loop must be seen low before the lane may trigger again.
        if (!deb_d[0]) begin
            armed_d = 1'b1;
        end
        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (deb_d[0] && armed_q) begin
                    state_d = CHECK;
                    qual_d  = badge_i;
                    armed_d = 1'b0;
                end
            end
            CHECK: begin
                timer_d = '0;
                state_d = grant_i ? OPEN : REJECT;
            end
            OPEN: begin
                if (pass_rise) begin
                    event_o = 1'b1;
                    state_d = CLOSE;
                    timer_d = '0;
                end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
                    state_d = CLOSE;
                    timer_d = '0;
                end
            end
            REJECT: begin
                timer_d = '0;
                if (!deb_d[0]) begin
                    state_d = IDLE;
                    qual_d  = 1'b0;
                end
            end
            CLOSE: begin
                // Hold here until the gap has elapsed and our event has left the arbiter.
                if (timer_q >= TW'(GAP_CYC - 1)) begin
                    timer_d = timer_q;
                    if (!busy_i) begin
                        state_d = IDLE;
                        qual_d  = 1'b0;
                        timer_d = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                qual_d  = 1'b0;
                timer_d = '0;
            end
        endcase
    end

    assign arm_o   = (state_q == OPEN);
    assign qual_o  = qual_q;
    assign state_o = state_q;

endmodule

// File: rtl/parking_gate_controller.sv
// Gate front end: entry/exit lanes, admission decision and a serialized car event stream.
// Define PARK_GATE_STATS_EN to add the saturating reject_count output.
module parking_gate_controller
    import parking_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 16,
    parameter int TIMEOUT_CYC  = 1000,
    parameter int GAP_CYC      = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  hour,
    input  logic        entry_loop,
    input  logic        entry_pass,
    input  logic        entry_uni_badge,
    input  logic        exit_loop,
    input  logic        exit_pass,
    input  logic        exit_uni_badge,
    output logic        entry_barrier_open,
    output logic        exit_barrier_open,
    output logic        entry_reject,
    output lane_state_e entry_state_dbg,
    output lane_state_e exit_state_dbg,
    parking_gate_controller_if.master evt
`ifdef PARK_GATE_STATS_EN
    ,output logic [15:0] reject_count
`endif
);

    logic        entry_evt, exit_evt, entry_qual, exit_qual, entry_grant;
    logic        entry_busy, exit_busy;
    logic        entry_pend_q, entry_pend_d, exit_pend_q, exit_pend_d;
    logic        car_entered_q, car_entered_d, car_exited_q, car_exited_d;
    lane_state_e entry_state, exit_state;

    // Uni badges may spill over into general spaces; general badges may not use uni spaces.
    assign entry_grant = hour_open(hour) &&
                         (entry_qual ? (evt.uni_is_vacated_space | evt.is_vacated_space)
                                     : evt.is_vacated_space);

    assign entry_busy = entry_pend_q | car_entered_q;
    assign exit_busy  = exit_pend_q  | car_exited_q;

    parking_lane_fsm #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .TIMEOUT_CYC  (TIMEOUT_CYC),
        .GAP_CYC      (GAP_CYC)
    ) u_entry_lane (
        .clk     (clk),
        .reset   (reset),
        .loop_i  (entry_loop),
        .pass_i  (entry_pass),
        .badge_i (entry_uni_badge),
        .grant_i (entry_grant),
        .busy_i  (entry_busy),
        .arm_o   (entry_barrier_open),
        .event_o (entry_evt),
        .qual_o  (entry_qual),
        .state_o (entry_state)
    );

    parking_lane_fsm #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .TIMEOUT_CYC  (TIMEOUT_CYC),
        .GAP_CYC      (GAP_CYC)
    ) u_exit_lane (
        .clk     (clk),
        .reset   (reset),
        .loop_i  (exit_loop),
        .pass_i  (exit_pass),
        .badge_i (exit_uni_badge),
        .grant_i (1'b1),
        .busy_i  (exit_busy),
        .arm_o   (exit_barrier_open),
        .event_o (exit_evt),
        .qual_o  (exit_qual),
        .state_o (exit_state)
    );

    // Entry wins a same-cycle collision; exit follows one cycle later.
    always_comb begin
        car_entered_d = entry_pend_q;
        car_exited_d  = exit_pend_q & ~entry_pend_q;
        entry_pend_d  = entry_evt | (entry_pend_q & ~car_entered_d);
        exit_pend_d   = exit_evt  | (exit_pend_q  & ~car_exited_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            entry_pend_q  <= 1'b0;
            exit_pend_q   <= 1'b0;
            car_entered_q <= 1'b0;
            car_exited_q  <= 1'b0;
        end else begin
            entry_pend_q  <= entry_pend_d;
            exit_pend_q   <= exit_pend_d;
            car_entered_q <= car_entered_d;
            car_exited_q  <= car_exited_d;
        end
    end

    assign evt.car_entered        = car_entered_q;
    assign evt.is_uni_car_entered = entry_qual;
    assign evt.car_exited         = car_exited_q;
    assign evt.is_uni_car_exited  = exit_qual;
    assign entry_reject           = (entry_state == REJECT);
    assign entry_state_dbg        = entry_state;
    assign exit_state_dbg         = exit_state;

`ifdef PARK_GATE_STATS_EN
    logic [15:0] reject_count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reject_count_q <= '0;
        end else if ((entry_state == CHECK) && !entry_grant && (reject_count_q != 16'hFFFF)) begin
            reject_count_q <= reject_count_q + 16'd1;
        end
    end

    assign reject_count = reject_count_q;
`endif

endmodule

// File: tb/tb_parking_gate_controller.sv
// Directed bench for parking_gate_controller: admission, timing, arbitration, timeout,
// reset and glitch rejection, with an event scoreboard checked at the end.
module tb_parking_gate_controller;
    import parking_pkg::*;

    logic        clk;
    logic        reset;
    logic [4:0]  hour;
    logic        entry_loop, entry_pass, entry_uni_badge;
    logic        exit_loop, exit_pass, exit_uni_badge;
    logic        entry_barrier_open, exit_barrier_open, entry_reject;
    lane_state_e entry_state_dbg, exit_state_dbg;
`ifdef PARK_GATE_STATS_EN
    logic [15:0] reject_count;
`endif

    parking_gate_controller_if evt_if ();

    parking_gate_controller dut (
        .clk                (clk),
        .reset              (reset),
        .hour               (hour),
        .entry_loop         (entry_loop),
        .entry_pass         (entry_pass),
        .entry_uni_badge    (entry_uni_badge),
        .exit_loop          (exit_loop),
        .exit_pass          (exit_pass),
        .exit_uni_badge     (exit_uni_badge),
        .entry_barrier_open (entry_barrier_open),
        .exit_barrier_open  (exit_barrier_open),
        .entry_reject       (entry_reject),
        .entry_state_dbg    (entry_state_dbg),
        .exit_state_dbg     (exit_state_dbg),
        .evt                (evt_if)
`ifdef PARK_GATE_STATS_EN
        ,.reject_count      (reject_count)
`endif
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Scoreboard: each event is {is_exit, qualifier}
    logic [1:0] exp_q[$];
    logic [1:0] obs_q[$];
    int         overlap_cnt = 0;
    int         n_vec = 0;
    int         n_err = 0;

    always @(negedge clk) begin
        if (!reset) begin
            if (evt_if.car_entered && evt_if.car_exited) overlap_cnt++;
            if (evt_if.car_entered) obs_q.push_back({1'b0, evt_if.is_uni_car_entered});
            if (evt_if.car_exited)  obs_q.push_back({1'b1, evt_if.is_uni_car_exited});
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drop_all();
        entry_loop = 1'b0; entry_pass = 1'b0;
        exit_loop  = 1'b0; exit_pass  = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        hour = 5'd0;
        entry_uni_badge = 1'b0; exit_uni_badge = 1'b0;
        drop_all();
        evt_if.uni_is_vacated_space = 1'b1;
        evt_if.is_vacated_space     = 1'b1;
        tick(2);
        check_val("rst_entry_arm", entry_barrier_open, 0);
        check_val("rst_exit_arm", exit_barrier_open, 0);
        check_val("rst_reject", entry_reject, 0);
        check_val("rst_entered", evt_if.car_entered, 0);
        check_val("rst_exited", evt_if.car_exited, 0);
        check_val("rst_entry_state", 32'(entry_state_dbg), 32'(IDLE));
`ifdef PARK_GATE_STATS_EN
        check_val("rst_reject_count", reject_count, 0);
`endif
        reset = 1'b0;
        tick(2);

        // 1: uni car admitted at hour 9; arm opens 19 cycles after the loop
        hour = 5'd9;
        entry_uni_badge = 1'b1;
        entry_loop = 1'b1;
        tick(18);
        check_val("t1_arm_before", entry_barrier_open, 0);
        check_val("t1_qual_check", evt_if.is_uni_car_entered, 1);
        tick(1);
        check_val("t1_arm_open", entry_barrier_open, 1);
        entry_pass = 1'b1;
        tick(18);
        check_val("t1_arm_closed", entry_barrier_open, 0);
        check_val("t1_no_pulse_yet", evt_if.car_entered, 0);
        tick(1);
        check_val("t1_pulse", evt_if.car_entered, 1);
        check_val("t1_pulse_qual", evt_if.is_uni_car_entered, 1);
        exp_q.push_back(2'b01);
        tick(1);
        check_val("t1_pulse_1cyc", evt_if.car_entered, 0);
        entry_pass = 1'b0;
        tick(40);
        check_val("t1_held_loop_idle", 32'(entry_state_dbg), 32'(IDLE));
        check_val("t1_held_loop_arm", entry_barrier_open, 0);
        check_val("t1_qual_cleared", evt_if.is_uni_car_entered, 0);
        entry_loop = 1'b0;
        tick(25);

        // 2: before opening hour -> reject
        hour = 5'd7;
        entry_uni_badge = 1'b0;
        entry_loop = 1'b1;
        tick(19);
        check_val("t2_reject", entry_reject, 1);
        check_val("t2_arm", entry_barrier_open, 0);
`ifdef PARK_GATE_STATS_EN
        check_val("t2_reject_count", reject_count, 1);
`endif
        entry_loop = 1'b0;
        tick(20);
        check_val("t2_reject_clear", entry_reject, 0);

        // 3a: uni car spills over into general space
        hour = 5'd10;
        evt_if.uni_is_vacated_space = 1'b0;
        evt_if.is_vacated_space     = 1'b1;
        entry_uni_badge = 1'b1;
        entry_loop = 1'b1;
        tick(19);
        check_val("t3_spill_arm", entry_barrier_open, 1);
        entry_pass = 1'b1;
        tick(19);
        check_val("t3_spill_pulse", evt_if.car_entered, 1);
        check_val("t3_spill_qual", evt_if.is_uni_car_entered, 1);
        exp_q.push_back(2'b01);
        drop_all();
        tick(30);

        // 3b: no space at all -> reject
        evt_if.is_vacated_space = 1'b0;
        entry_loop = 1'b1;
        tick(19);
        check_val("t3_full_reject", entry_reject, 1);
        entry_loop = 1'b0;
        tick(20);

        // 3c: general car cannot take a uni space
        evt_if.uni_is_vacated_space = 1'b1;
        entry_uni_badge = 1'b0;
        entry_loop = 1'b1;
        tick(19);
        check_val("t3_gen_reject", entry_reject, 1);
`ifdef PARK_GATE_STATS_EN
        check_val("t3_reject_count", reject_count, 3);
`endif
        entry_loop = 1'b0;
        tick(20);

        // 4: simultaneous entry/exit passes serialize, entry first
        hour = 5'd12;
        evt_if.is_vacated_space = 1'b1;
        entry_uni_badge = 1'b0;
        exit_uni_badge  = 1'b1;
        entry_loop = 1'b1;
        exit_loop  = 1'b1;
        tick(19);
        check_val("t4_entry_arm", entry_barrier_open, 1);
        check_val("t4_exit_arm", exit_barrier_open, 1);
        entry_pass = 1'b1;
        exit_pass  = 1'b1;
        tick(19);
        check_val("t4_entered_n", evt_if.car_entered, 1);
        check_val("t4_exited_n", evt_if.car_exited, 0);
        check_val("t4_entry_qual", evt_if.is_uni_car_entered, 0);
        exp_q.push_back(2'b00);
        tick(1);
        check_val("t4_entered_n1", evt_if.car_entered, 0);
        check_val("t4_exited_n1", evt_if.car_exited, 1);
        check_val("t4_exit_qual", evt_if.is_uni_car_exited, 1);
        exp_q.push_back(2'b11);
        drop_all();
        tick(30);

        // 5: timeout with no pass closes the arm silently
        entry_loop = 1'b1;
        tick(19);
        check_val("t5_arm_open", entry_barrier_open, 1);
        tick(999);
        check_val("t5_arm_still_open", entry_barrier_open, 1);
        tick(1);
        check_val("t5_arm_timeout", entry_barrier_open, 0);
        entry_loop = 1'b0;
        tick(25);

        // 5b: reset in the middle of OPEN drops everything at once
        entry_loop = 1'b1;
        tick(19);
        check_val("t5_reopen", entry_barrier_open, 1);
        entry_pass = 1'b1;
        tick(10);
        reset = 1'b1;
        #1;
        check_val("t5_rst_arm", entry_barrier_open, 0);
        check_val("t5_rst_state", 32'(entry_state_dbg), 32'(IDLE));
        check_val("t5_rst_entered", evt_if.car_entered, 0);
        drop_all();
        tick(2);
        reset = 1'b0;
        tick(40);
        check_val("t5_post_rst_state", 32'(entry_state_dbg), 32'(IDLE));

        // 6: 5 ns glitches straddling a clock edge are filtered
        for (int i = 0; i < 8; i++) begin
            #6;
            entry_loop = 1'b1;
            exit_pass  = 1'b1;
            #5;
            entry_loop = 1'b0;
            exit_pass  = 1'b0;
            tick(3);
        end
        tick(20);
        check_val("t6_entry_state", 32'(entry_state_dbg), 32'(IDLE));
        check_val("t6_entry_arm", entry_barrier_open, 0);
        check_val("t6_exit_state", 32'(exit_state_dbg), 32'(IDLE));

        // Final scoreboard
        check_val("evt_count", obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            check_val($sformatf("evt_%0d", i), 32'(obs_q[i]), 32'(exp_q[i]));
        end
        check_val("no_overlap", overlap_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
